// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: register read/write sequencer for a byte-level I2C master.
// req_* accepts an access, m_* drives/observes the master, rsp_* reports it.
module i2c_reg_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       m_ena,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_data_wr,
  input  logic       m_busy,
  input  logic [7:0] m_data_rd,
  input  logic       m_ack_error
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, START, BYTE1, BYTE2, FINISH, RESP
  } state_e;

  state_e        state_q;
  logic          busy_q;
  logic          rw_q;
  logic          err_q;
  logic [7:0]    wdata_q;
  logic [CW-1:0] cnt_q;

  logic busy_rise;
  logic busy_fall;
  logic busy_edge;
  logic hs;
  logic active;
  logic tmo;

  assign busy_rise = m_busy & ~busy_q;
  assign busy_fall = ~m_busy & busy_q;
  assign busy_edge = busy_rise | busy_fall;
  assign req_ready = (state_q == IDLE) & ~m_busy;
  assign hs        = req_valid & req_ready;
  assign active    = (state_q != IDLE) & (state_q != RESP);
  // a busy edge restarts the count, so it wins over an expiring timer
  assign tmo       = active & ~busy_edge &
                     (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b1;
      rw_q      <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      m_ena     <= 1'b0;
      m_addr    <= '0;
      m_rw      <= 1'b0;
      m_data_wr <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      busy_q    <= m_busy;
      rsp_valid <= 1'b0;
      if (busy_edge) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (active & m_ack_error) begin
        err_q <= 1'b1;
      end
      if (tmo) begin
        m_ena     <= 1'b0;
        err_q     <= 1'b1;
        rsp_valid <= 1'b1;
        cnt_q     <= '0;
        state_q   <= RESP;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (hs) begin
              rw_q      <= req_rw;
              wdata_q   <= req_wdata;
              err_q     <= 1'b0;
              m_ena     <= 1'b1;
              m_addr    <= req_dev;
              m_rw      <= 1'b0;
              m_data_wr <= req_reg;
              state_q   <= START;
            end
          end
          START: begin
            if (busy_rise) begin
              // queue the second byte while the pointer byte is on the bus
              if (rw_q) begin
                m_rw <= 1'b1;
              end else begin
                m_data_wr <= wdata_q;
              end
              state_q <= BYTE1;
            end
          end
          BYTE1: begin
            if (busy_rise) begin
              m_ena   <= 1'b0;
              state_q <= BYTE2;
            end
          end
          BYTE2: begin
            if (busy_fall) begin
              if (rw_q) begin
                rsp_rdata <= m_data_rd;
              end
              state_q <= FINISH;
            end
          end
          FINISH: begin
            if (busy_rise) begin
              err_q <= 1'b1;
            end else if (!m_busy) begin
              rsp_valid <= 1'b1;
              cnt_q     <= '0;
              state_q   <= RESP;
            end
          end
          RESP: begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: scoreboard bench with a byte-level I2C master model.
// Expected commands/responses are queued at request time, checked on output.
module tb_i2c_reg_ctrl;

  localparam int TMO  = 50;
  localparam int BLEN = 8;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       m_ena;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_data_wr;
  logic       m_busy;
  logic [7:0] m_data_rd = '0;
  logic       m_ack_error = 1'b0;

  logic       mdl_busy = 1'b0;
  logic       hold_busy = 1'b0;
  logic       mdl_on = 1'b1;
  logic       nack_b1 = 1'b0;
  logic [7:0] rd_val = '0;
  logic [7:0] last_rd = '0;

  logic [15:0] cmd_log [0:255];
  int          log_n = 0;
  int          log_rd = 0;

  rsp_t        exp_rsp[$];
  logic [15:0] exp_cmd[$];

  int vecs = 0;
  int errs = 0;

  assign m_busy = mdl_busy | hold_busy;

  always #5 clk = ~clk;

  i2c_reg_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rw      (req_rw),
    .req_dev     (req_dev),
    .req_reg     (req_reg),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .m_ena       (m_ena),
    .m_addr      (m_addr),
    .m_rw        (m_rw),
    .m_data_wr   (m_data_wr),
    .m_busy      (m_busy),
    .m_data_rd   (m_data_rd),
    .m_ack_error (m_ack_error)
  );

  // master model: busy high per byte, low between bytes; continues
  // while ena is still high one cycle after a byte, else stops
  initial begin : master
    bit more;
    bit first;
    forever begin
      @(posedge clk); #1;
      if (mdl_on && m_ena) begin
        repeat (2) @(posedge clk);
        #1;
        more  = 1'b1;
        first = 1'b1;
        while (more) begin
          cmd_log[log_n % 256] = {m_addr, m_rw, m_data_wr};
          log_n    = log_n + 1;
          mdl_busy = 1'b1;
          repeat (BLEN) @(posedge clk);
          #1;
          if (m_rw) m_data_rd = rd_val;
          if (first && nack_b1) m_ack_error = 1'b1;
          mdl_busy = 1'b0;
          @(posedge clk); #1;
          m_ack_error = 1'b0;
          more  = m_ena;
          first = 1'b0;
        end
        repeat (3) @(posedge clk);
      end
    end
  end

  task automatic drive_req(input logic rw, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd,
                           output bit hs_ok);
    rsp_t r;
    if (mdl_on) begin
      exp_cmd.push_back({dev, 1'b0, rg});
      exp_cmd.push_back(rw ? {dev, 1'b1, rg} : {dev, 1'b0, wd});
      if (rw) last_rd = rd_val;
      r.err = nack_b1;
    end else begin
      r.err = 1'b1;
    end
    r.rdata = last_rd;
    exp_rsp.push_back(r);
    req_rw    = rw;
    req_dev   = dev;
    req_reg   = rg;
    req_wdata = wd;
    req_valid = 1'b1;
    hs_ok     = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        hs_ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic await_rsp(output bit got, output rsp_t obs,
                           output int cyc, output logic after);
    got   = 1'b0;
    obs   = '0;
    cyc   = 0;
    after = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid) begin
        got = 1'b1;
        obs = {rsp_rdata, rsp_err};
        break;
      end
    end
    @(posedge clk); #1;
    after = rsp_valid;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    hold_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got %b want 0", req_ready); end
    vecs++; if (m_ena !== 1'b0) begin errs++; $display("FAIL rst_ena got %b want 0", m_ena); end
    vecs++; if (m_addr !== 7'h00) begin errs++; $display("FAIL rst_addr got %h want 00", m_addr); end
    vecs++; if (m_rw !== 1'b0) begin errs++; $display("FAIL rst_rw got %b want 0", m_rw); end
    vecs++; if (m_data_wr !== 8'h00) begin errs++; $display("FAIL rst_data_wr got %h want 00", m_data_wr); end
    vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    vecs++; if (rsp_rdata !== 8'h00) begin errs++; $display("FAIL rst_rdata got %h want 00", rsp_rdata); end
    vecs++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL rst_err got %b want 0", rsp_err); end
  endtask

  task automatic test_busy_hold;
    bit hs; bit got; rsp_t obs; rsp_t er; int cyc; logic after;
    logic [15:0] ec; int n0;
    req_rw = 1'b0; req_dev = 7'h11; req_reg = 8'h22; req_wdata = 8'h33;
    req_valid = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (req_ready !== 1'b0 || m_ena !== 1'b0) begin
        errs++;
        $display("FAIL hold_blocked cyc=%0d ready=%b ena=%b want 0/0", i, req_ready, m_ena);
      end
    end
    hold_busy = 1'b0;
    drive_req(1'b0, 7'h11, 8'h22, 8'h33, hs);
    vecs++; if (!hs) begin errs++; $display("FAIL hold_handshake got none want 1"); end
    await_rsp(got, obs, cyc, after);
    er = exp_rsp.pop_front();
    vecs++;
    if (!got) begin errs++; $display("FAIL hold_rsp got no rsp_valid want one"); end
    else if (obs !== er) begin errs++; $display("FAIL hold_rsp got %h/%b want %h/%b", obs.rdata, obs.err, er.rdata, er.err); end
    while (exp_cmd.size() > 0) begin
      ec = exp_cmd.pop_front(); vecs++;
      if (log_rd >= log_n) begin errs++; $display("FAIL hold_cmd got none want %h", ec); end
      else begin
        if (cmd_log[log_rd % 256] !== ec) begin errs++; $display("FAIL hold_cmd got %h want %h", cmd_log[log_rd % 256], ec); end
        log_rd++;
      end
    end
    n0 = log_n;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (rsp_valid !== 1'b0) begin errs++; $display("FAIL hold_single got rsp_valid=1 want 0"); end
    end
    vecs++; if (log_n !== n0) begin errs++; $display("FAIL hold_single_cmds got %0d want %0d", log_n, n0); end
  endtask

  task automatic test_write;
    bit hs; bit got; rsp_t obs; rsp_t er; int cyc; logic after; logic [15:0] ec;
    drive_req(1'b0, 7'h50, 8'h10, 8'hA5, hs);
    vecs++; if (!hs) begin errs++; $display("FAIL wr_handshake got none want 1"); end
    await_rsp(got, obs, cyc, after);
    er = exp_rsp.pop_front();
    vecs++;
    if (!got) begin errs++; $display("FAIL wr_rsp got no rsp_valid want one"); end
    else if (obs !== er) begin errs++; $display("FAIL wr_rsp got %h/%b want %h/%b", obs.rdata, obs.err, er.rdata, er.err); end
    vecs++; if (after !== 1'b0) begin errs++; $display("FAIL wr_pulse got 2+ cycles want 1"); end
    while (exp_cmd.size() > 0) begin
      ec = exp_cmd.pop_front(); vecs++;
      if (log_rd >= log_n) begin errs++; $display("FAIL wr_cmd got none want %h", ec); end
      else begin
        if (cmd_log[log_rd % 256] !== ec) begin errs++; $display("FAIL wr_cmd got %h want %h", cmd_log[log_rd % 256], ec); end
        log_rd++;
      end
    end
  endtask

  task automatic test_read;
    bit hs; bit got; rsp_t obs; rsp_t er; int cyc; logic after; logic [15:0] ec;
    rd_val = 8'h3C;
    drive_req(1'b1, 7'h50, 8'h20, 8'hEE, hs);
    vecs++; if (!hs) begin errs++; $display("FAIL rd_handshake got none want 1"); end
    await_rsp(got, obs, cyc, after);
    er = exp_rsp.pop_front();
    vecs++;
    if (!got) begin errs++; $display("FAIL rd_rsp got no rsp_valid want one"); end
    else if (obs !== er) begin errs++; $display("FAIL rd_rsp got %h/%b want %h/%b", obs.rdata, obs.err, er.rdata, er.err); end
    vecs++; if (after !== 1'b0) begin errs++; $display("FAIL rd_pulse got 2+ cycles want 1"); end
    while (exp_cmd.size() > 0) begin
      ec = exp_cmd.pop_front(); vecs++;
      if (log_rd >= log_n) begin errs++; $display("FAIL rd_cmd got none want %h", ec); end
      else begin
        if (cmd_log[log_rd % 256] !== ec) begin errs++; $display("FAIL rd_cmd got %h want %h", cmd_log[log_rd % 256], ec); end
        log_rd++;
      end
    end
  endtask

  task automatic test_nack;
    bit hs; bit got; rsp_t obs; rsp_t er; int cyc; logic after; logic [15:0] ec;
    for (int k = 0; k < 2; k++) begin
      nack_b1 = (k == 0);
      drive_req(1'b0, 7'h50, 8'h11 + 8'(k), 8'hC3, hs);
      vecs++; if (!hs) begin errs++; $display("FAIL nack_handshake k=%0d got none", k); end
      await_rsp(got, obs, cyc, after);
      er = exp_rsp.pop_front();
      vecs++;
      if (!got) begin errs++; $display("FAIL nack_rsp k=%0d got no rsp_valid want one", k); end
      else if (obs !== er) begin errs++; $display("FAIL nack_rsp k=%0d got %h/%b want %h/%b", k, obs.rdata, obs.err, er.rdata, er.err); end
      while (exp_cmd.size() > 0) begin
        ec = exp_cmd.pop_front(); vecs++;
        if (log_rd >= log_n) begin errs++; $display("FAIL nack_cmd got none want %h", ec); end
        else begin
          if (cmd_log[log_rd % 256] !== ec) begin errs++; $display("FAIL nack_cmd got %h want %h", cmd_log[log_rd % 256], ec); end
          log_rd++;
        end
      end
    end
    nack_b1 = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit hs; bit got; rsp_t obs; rsp_t er; int cyc; logic after; logic [15:0] ec;
    logic rw; logic [6:0] dv; logic [7:0] rg; logic [7:0] wd;
    for (int k = 0; k < 6; k++) begin
      rw = 1'($urandom_range(0, 1));
      dv = 7'($urandom);
      rg = 8'($urandom);
      wd = 8'($urandom);
      rd_val = 8'($urandom);
      drive_req(rw, dv, rg, wd, hs);
      vecs++; if (!hs) begin errs++; $display("FAIL b2b_handshake k=%0d got none", k); end
      await_rsp(got, obs, cyc, after);
      er = exp_rsp.pop_front();
      vecs++;
      if (!got) begin errs++; $display("FAIL b2b_rsp k=%0d got no rsp_valid want one", k); end
      else if (obs !== er) begin errs++; $display("FAIL b2b_rsp k=%0d got %h/%b want %h/%b", k, obs.rdata, obs.err, er.rdata, er.err); end
      while (exp_cmd.size() > 0) begin
        ec = exp_cmd.pop_front(); vecs++;
        if (log_rd >= log_n) begin errs++; $display("FAIL b2b_cmd got none want %h", ec); end
        else begin
          if (cmd_log[log_rd % 256] !== ec) begin errs++; $display("FAIL b2b_cmd got %h want %h", cmd_log[log_rd % 256], ec); end
          log_rd++;
        end
      end
    end
  endtask

  task automatic test_timeout;
    bit hs; bit got; rsp_t obs; rsp_t er; int cyc; logic after;
    mdl_on = 1'b0;
    drive_req(1'b0, 7'h50, 8'h10, 8'h01, hs);
    vecs++; if (!hs) begin errs++; $display("FAIL tmo_handshake got none want 1"); end
    vecs++; if (m_ena !== 1'b1) begin errs++; $display("FAIL tmo_ena_start got %b want 1", m_ena); end
    await_rsp(got, obs, cyc, after);
    er = exp_rsp.pop_front();
    vecs++;
    if (!got) begin errs++; $display("FAIL tmo_rsp got no rsp_valid want one"); end
    else if (obs !== er) begin errs++; $display("FAIL tmo_rsp got %h/%b want %h/%b", obs.rdata, obs.err, er.rdata, er.err); end
    vecs++; if (cyc !== TMO) begin errs++; $display("FAIL tmo_cycles got %0d want %0d", cyc, TMO); end
    vecs++; if (m_ena !== 1'b0) begin errs++; $display("FAIL tmo_ena_drop got %b want 0", m_ena); end
    mdl_on = 1'b1;
  endtask

  task automatic test_reset_byte2;
    bit hs; bit seen; logic [15:0] ec; rsp_t er;
    rd_val = 8'h77;
    drive_req(1'b1, 7'h50, 8'h30, 8'h00, hs);
    vecs++; if (!hs) begin errs++; $display("FAIL rb2_handshake got none want 1"); end
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (m_ena === 1'b0) begin seen = 1'b1; break; end
    end
    vecs++; if (!seen) begin errs++; $display("FAIL rb2_reach got no ena drop want drop"); end
    reset_n = 1'b0;
    #1;
    vecs++; if (m_ena !== 1'b0) begin errs++; $display("FAIL rb2_ena got %b want 0", m_ena); end
    vecs++; if (m_addr !== 7'h00) begin errs++; $display("FAIL rb2_addr got %h want 00", m_addr); end
    vecs++; if (m_rw !== 1'b0) begin errs++; $display("FAIL rb2_rw got %b want 0", m_rw); end
    vecs++; if (m_data_wr !== 8'h00) begin errs++; $display("FAIL rb2_data_wr got %h want 00", m_data_wr); end
    vecs++; if (rsp_rdata !== 8'h00) begin errs++; $display("FAIL rb2_rdata got %h want 00", rsp_rdata); end
    vecs++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL rb2_err got %b want 0", rsp_err); end
    er = exp_rsp.pop_back();
    last_rd = 8'h00;
    while (exp_cmd.size() > 0) begin
      ec = exp_cmd.pop_front(); vecs++;
      if (log_rd >= log_n) begin errs++; $display("FAIL rb2_cmd got none want %h", ec); end
      else begin
        if (cmd_log[log_rd % 256] !== ec) begin errs++; $display("FAIL rb2_cmd got %h want %h", cmd_log[log_rd % 256], ec); end
        log_rd++;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rb2_no_rsp cyc=%0d got 1 want 0", i); end
    end
  endtask

  initial begin
    test_reset();
    test_busy_hold();
    test_write();
    test_read();
    test_nack();
    test_back_to_back();
    test_timeout();
    test_reset_byte2();
    test_write();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
